// File: rtl/quad_enc_decoder_pkg.sv
// Shared types and the quadrature transition decoder for quad_enc_decoder.
// Transitions are classified on a 2-bit Gray position index.
package quad_enc_decoder_pkg;

    typedef enum logic {INIT, RUN} qdec_state_e;

    typedef logic [1:0] quad_t;

    localparam int unsigned INIT_CYCLES = 3;

    typedef struct packed {
        logic signed [1:0] step;
        logic              illegal;
    } quad_step_t;

    // {a,b} -> {b, a^b} maps the CW sequence 00,10,11,01 onto 0,1,2,3.
    function automatic quad_step_t quad_step(input quad_t prev, input quad_t cur);
        quad_step_t r;
        logic [1:0] p_prev;
        logic [1:0] p_cur;
        logic [1:0] delta;
        p_prev    = {prev[0], prev[1] ^ prev[0]};
        p_cur     = {cur[0], cur[1] ^ cur[0]};
        delta     = p_cur - p_prev;
        r.step    = 2'sb00;
        r.illegal = 1'b0;
        unique case (delta)
            2'd1:    r.step = 2'sb01;
            2'd3:    r.step = 2'sb11;
            2'd2:    r.illegal = 1'b1;
            default: r.step = 2'sb00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/quad_enc_decoder_glitch_filter.sv
// One encoder channel: two-flop synchroniser followed by a hold-time glitch filter.
// bypass_i loads the synchronised value straight into the filter output.
module quad_enc_decoder_glitch_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    input  logic bypass_i,
    output logic s_o,
    output logic f_o
);

    logic [1:0] sync_q;
    logic       s;
    logic       f_q, f_d;
    logic [7:0] c_q, c_d;

    assign s = sync_q[1];

    always_comb begin
        f_d = f_q;
        c_d = c_q;
        if (bypass_i) begin
            f_d = s;
            c_d = '0;
        end else if (s == f_q) begin
            c_d = '0;
        end else if (c_q == 8'(FILT_LEN - 1)) begin
            f_d = s;
            c_d = '0;
        end else begin
            c_d = c_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            f_q    <= 1'b0;
            c_q    <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            f_q    <= f_d;
            c_q    <= c_d;
        end
    end

    assign s_o = s;
    assign f_o = f_q;

endmodule

// File: rtl/quad_enc_decoder.sv
// Filtered x4 quadrature decoder with signed position, step/dir pulses and error counting.
// Define QDEC_INDEX_EN to add the index channel (z_i, idx_pos_o, idx_hit_o).
module quad_enc_decoder
    import quad_enc_decoder_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             a_i,
    input  logic             b_i,
`ifdef QDEC_INDEX_EN
    input  logic             z_i,
    output logic [CNT_W-1:0] idx_pos_o,
    output logic             idx_hit_o,
`endif
    input  logic             clr_i,
    output logic [CNT_W-1:0] pos_o,
    output logic             step_cw_o,
    output logic             step_ccw_o,
    output logic             dir_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    qdec_state_e      state_q, state_d;
    logic [1:0]       init_cnt_q, init_cnt_d;
    quad_t            prev_q, prev_d;
    quad_t            cur, cur_sync;
    quad_step_t       step_res;
    logic             in_init;
    logic             sa, sb, fa, fb;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_cw_q, step_cw_d;
    logic             step_ccw_q, step_ccw_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    assign in_init  = (state_q == INIT);
    assign cur      = {fa, fb};
    assign cur_sync = {sa, sb};

    quad_enc_decoder_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (a_i),
        .bypass_i(in_init),
        .s_o     (sa),
        .f_o     (fa)
    );

    quad_enc_decoder_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (b_i),
        .bypass_i(in_init),
        .s_o     (sb),
        .f_o     (fb)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = prev_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        err_cnt_d  = err_cnt_q;
        step_cw_d  = 1'b0;
        step_ccw_d = 1'b0;
        err_d      = 1'b0;
        step_res   = quad_step(prev_q, cur);
        unique case (state_q)
            INIT: begin
                // Prime from the value the filters load on this same edge.
                prev_d = cur_sync;
                if (init_cnt_q == 2'(INIT_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end
            RUN: begin
                prev_d = cur;
                if (step_res.illegal) begin
                    err_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end else if (step_res.step == 2'sb01) begin
                    pos_d     = pos_q + CNT_W'(1);
                    step_cw_d = 1'b1;
                    dir_d     = 1'b0;
                end else if (step_res.step == 2'sb11) begin
                    pos_d      = pos_q - CNT_W'(1);
                    step_ccw_d = 1'b1;
                    dir_d      = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
        if (clr_i) begin
            pos_d     = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            prev_q     <= '0;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            step_cw_q  <= 1'b0;
            step_ccw_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_q     <= prev_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            step_cw_q  <= step_cw_d;
            step_ccw_q <= step_ccw_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign pos_o      = pos_q;
    assign dir_o      = dir_q;
    assign step_cw_o  = step_cw_q;
    assign step_ccw_o = step_ccw_q;
    assign err_o      = err_q;
    assign err_cnt_o  = err_cnt_q;

`ifdef QDEC_INDEX_EN
    logic             sz, fz;
    logic             z_prev_q, z_prev_d;
    logic [CNT_W-1:0] idx_pos_q, idx_pos_d;
    logic             idx_hit_q, idx_hit_d;

    quad_enc_decoder_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (z_i),
        .bypass_i(in_init),
        .s_o     (sz),
        .f_o     (fz)
    );

    always_comb begin
        z_prev_d  = in_init ? sz : fz;
        idx_pos_d = idx_pos_q;
        idx_hit_d = 1'b0;
        if (!in_init && fz && !z_prev_q) begin
            idx_pos_d = pos_q;
            idx_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            z_prev_q  <= 1'b0;
            idx_pos_q <= '0;
            idx_hit_q <= 1'b0;
        end else begin
            z_prev_q  <= z_prev_d;
            idx_pos_q <= idx_pos_d;
            idx_hit_q <= idx_hit_d;
        end
    end

    assign idx_pos_o = idx_pos_q;
    assign idx_hit_o = idx_hit_q;
`endif

endmodule

// File: doc/quad_enc_decoder.md
Name: quad_enc_decoder

Overview:
Consumes raw quadrature encoder lines (a, b) from a mechanical or optical encoder and produces a filtered, signed x4 position count.
- Each input is synchronised and glitch-filtered.
- Outputs: per-step direction pulses, a sticky direction flag and illegal-transition reporting.
- Sits between board pins (or the SimSrcGen QuadEncGo stimulus in benches) and the user-interface logic.

Parameters:
- CNT_W, 16, width of the signed position counter.
- FILT_LEN, 4, consecutive cycles a synchronised input must hold a new value before it is accepted; legal range 1..255.
- ERR_W, 8, width of the saturating illegal-transition counter.

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- a  in  1  raw encoder channel A, asynchronous to clk.
- b  in  1  raw encoder channel B, asynchronous to clk.
- clr  in  1  synchronous clear of pos and err_cnt.
- pos  out  CNT_W  signed two's-complement position.
- step_cw  out  1  one-cycle pulse per legal clockwise transition.
- step_ccw  out  1  one-cycle pulse per legal counter-clockwise transition.
- dir  out  1  direction of last legal step: 1 = ccw, 0 = cw.
- err  out  1  one-cycle pulse on an illegal transition.
- err_cnt  out  ERR_W  saturating count of illegal transitions.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low. All registers clear on rst_n=0.
- Reset values: pos=0, step_cw=0, step_ccw=0, dir=0, err=0, err_cnt=0. Sync flops, filter counters and filtered values are 0; FSM in INIT.
- Synchroniser: two-flop synchroniser per channel, giving s.
- Filter, per channel, with filtered value f and counter c:
  - if s==f: c<=0;
  - else if c==FILT_LEN-1: f<=s, c<=0;
  - else c<=c+1.
  - A pulse on s shorter than FILT_LEN cycles is discarded.
- Latency: a clean input edge reaches f after 2+FILT_LEN clk edges. Outputs update on the next edge, so total latency is 3+FILT_LEN cycles (7 at defaults).
- FSM states INIT and RUN.
  - INIT: lasts exactly 3 cycles after rst_n deassertion. f<=s directly, with no filtering. prev<={fa,fb}. No step or err outputs. Then go to RUN.
  - RUN: each cycle compare prev with cur={fa,fb}, then set prev<=cur.
- Decode in RUN, state written as {a,b}:
  - CW sequence: 00->10->11->01->00. Each CW transition gives pos+1, step_cw=1, dir=0.
  - CCW sequence: 00->01->11->10->00. Each CCW transition gives pos-1, step_ccw=1, dir=1.
  - prev==cur: no action.
  - Both bits change (00<->11, 10<->01): err=1, err_cnt+1 saturating at all-ones. pos and dir are unchanged.
- Wrap: pos wraps modulo 2^CNT_W. 0x7FFF+1 gives 0x8000; 0x0000-1 gives 0xFFFF.
- clr vs step: when clr coincides with a step, clr wins and pos=0. The step pulse and dir still update as decoded.
- clr vs err: clr also zeroes err_cnt; a coincident err still pulses err.
- Reset mid-operation: asynchronous return to reset values and INIT. No spurious step after release, because INIT primes prev from the live inputs.

Optional Feature:
- Macro QDEC_INDEX_EN.
- Defined:
  - Adds ports z (in, 1, index channel), idx_pos (out, CNT_W, pos latched at index, reset 0) and idx_hit (out, 1, one-cycle pulse, reset 0).
  - z uses the same sync+filter path, primed in INIT.
  - A rising edge of filtered z in RUN latches the current pos (pre-update value of that cycle) into idx_pos and pulses idx_hit.
  - clr does not affect idx_pos.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package QuadDecPkg holds:
  - typedef enum logic {INIT, RUN} qdec_state_e;
  - typedef logic [1:0] quad_t;
  - localparam INIT_CYCLES = 3;
  - automatic function quad_step(prev, cur), returning a signed 2-bit step (-1, 0 or +1) plus an illegal flag.
- Sub-module glitch_filter (parameter FILT_LEN) covers one channel: synchroniser, filter counter and INIT bypass input. It is instantiated twice, or three times with QDEC_INDEX_EN.

Test Plan:
- Reset with a=b=1 held, then release rst_n → no step or err pulses; pos=0 through INIT and RUN.
- One CW QuadEncGo cycle, qprd=20 cycles → four step_cw pulses; pos=4; dir=0; first pulse 7 cycles after a rises.
- Two CCW cycles from pos=4 → eight step_ccw pulses; pos=-4 (0xFFFC); dir=1.
- 3-cycle glitches on a while b=0 (repeated 30 times) → no steps and no err; pos unchanged.
- Force 00->11 with a and b toggling together → err pulses once; err_cnt=1; pos unchanged. After 300 such events, err_cnt saturates at 255.
- Preload pos=0x7FFF via a CW run, then one more CW step → pos=0x8000. clr asserted coincident with a step → pos=0 while step_cw still pulses.
